// File: rtl/lbist_pkg.sv
// Shared LBIST definitions: TPG state encoding, default feedback polynomials
// and the LFSR step function used by both the pattern generator and the MISR.
package lbist_pkg;

  localparam int LFSR_MAX_W = 64;

  typedef logic [LFSR_MAX_W-1:0] lfsr_word_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } tpg_state_t;

  localparam logic [3:0]  POLY_W4  = 4'hC;
  localparam logic [7:0]  POLY_W8  = 8'hB8;
  localparam logic [15:0] POLY_W16 = 16'hB400;

  function automatic logic parity(input lfsr_word_t value);
    return ^value;
  endfunction

  // Callers zero-extend narrower registers and keep only their own low bits.
  function automatic lfsr_word_t lfsr_next(input lfsr_word_t value, input lfsr_word_t poly);
    return (value << 1) | lfsr_word_t'(parity(value & poly));
  endfunction

endpackage

// File: rtl/tpg_lfsr.sv
// LBIST test pattern generator: emits NUM_PATTERNS Fibonacci-LFSR patterns,
// one per enabled cycle, and pulses tpg_end alongside the final one.
module tpg_lfsr
  import lbist_pkg::*;
#(
  parameter int               WIDTH        = 8,
  parameter logic [WIDTH-1:0] POLY         = WIDTH'(POLY_W8),
  parameter logic [WIDTH-1:0] SEED         = WIDTH'(8'h01),
  parameter int               NUM_PATTERNS = 255,
  parameter int               CNT_W        = $clog2(NUM_PATTERNS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tpg_reset,
  input  logic             enable,
  output logic [WIDTH-1:0] pattern,
  output logic             pattern_valid,
  output logic [CNT_W-1:0] pattern_idx,
  output logic             tpg_end
);

  // An all-zero seed would lock the LFSR, so it is replaced by 1.
  localparam logic [WIDTH-1:0] SEED_EFF = (SEED == '0) ? WIDTH'(1) : SEED;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_PATTERNS - 1);

  tpg_state_t       state_r;
  tpg_state_t       state_s;
  logic [WIDTH-1:0] lfsr_r;
  logic [WIDTH-1:0] lfsr_s;
  logic [CNT_W-1:0] count_r;
  logic [CNT_W-1:0] count_s;
  logic [WIDTH-1:0] pattern_s;
  logic [CNT_W-1:0] idx_s;
  logic             valid_s;
  logic             end_s;

  // Next-state and next-output decode; restart outranks everything else.
  always_comb begin
    state_s   = state_r;
    lfsr_s    = lfsr_r;
    count_s   = count_r;
    pattern_s = pattern;
    idx_s     = pattern_idx;
    valid_s   = 1'b0;
    end_s     = 1'b0;
    if (tpg_reset) begin
      state_s   = IDLE;
      lfsr_s    = SEED_EFF;
      count_s   = '0;
      pattern_s = '0;
      idx_s     = '0;
    end else begin
      case (state_r)
        IDLE, RUN: begin
          if (enable) begin
            pattern_s = lfsr_r;
            idx_s     = count_r;
            valid_s   = 1'b1;
            lfsr_s    = WIDTH'(lfsr_next(lfsr_word_t'(lfsr_r), lfsr_word_t'(POLY)));
            // The counter parks on the last index instead of wrapping.
            if (count_r == LAST_IDX) begin
              state_s = DONE;
              end_s   = 1'b1;
            end else begin
              state_s = RUN;
              count_s = count_r + CNT_W'(1);
            end
          end else begin
            valid_s = 1'b0;
          end
        end
        DONE: begin
          state_s = DONE;
        end
        default: begin
          state_s = IDLE;
          lfsr_s  = SEED_EFF;
          count_s = '0;
        end
      endcase
    end
  end

  // State, LFSR, counter and all outputs are registered together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r       <= IDLE;
      lfsr_r        <= SEED_EFF;
      count_r       <= '0;
      pattern       <= '0;
      pattern_idx   <= '0;
      pattern_valid <= 1'b0;
      tpg_end       <= 1'b0;
    end else begin
      state_r       <= state_s;
      lfsr_r        <= lfsr_s;
      count_r       <= count_s;
      pattern       <= pattern_s;
      pattern_idx   <= idx_s;
      pattern_valid <= valid_s;
      tpg_end       <= end_s;
    end
  end

endmodule
